ber_measure_ctrl: RTL and testbench

//  Sequences one bit-error-ratio measurement window over the byte stream seen by the error checker.

---
 rtl/ber_pkg.sv | 16 +
 rtl/ber_measure_ctrl_if.sv | 45 ++++
 rtl/bit_err_popcnt.sv | 26 ++
 rtl/ber_measure_ctrl.sv | 128 ++++++++++++
 tb/tb_ber_measure_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the BER measurement controller: FSM state encoding
// and default datapath widths.
package ber_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_WIN_W = 32;
    localparam int DEF_CNT_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } ber_state_e;

endpackage

// File: rtl/ber_measure_ctrl_if.sv
// Host/stream-side bundle of the BER measurement controller.
// Optional alarm signals exist only when BER_ALARM_EN is defined.
interface ber_measure_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int WIN_W = 32,
    parameter int CNT_W = 40
) ();

    logic             start;
    logic             abort;
    logic [WIN_W-1:0] win_len;
    logic             byte_valid;
    logic [WIDTH-1:0] tx_byte;
    logic [WIDTH-1:0] rx_byte;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_bits;
    logic [WIN_W-1:0] err_bytes;
    logic [WIN_W-1:0] byte_cnt;
`ifdef BER_ALARM_EN
    logic [CNT_W-1:0] err_thresh;
    logic             alarm;

    modport master (
        output start, abort, win_len, byte_valid, tx_byte, rx_byte, err_thresh,
        input  busy, done, err_bits, err_bytes, byte_cnt, alarm
    );

    modport slave (
        input  start, abort, win_len, byte_valid, tx_byte, rx_byte, err_thresh,
        output busy, done, err_bits, err_bytes, byte_cnt, alarm
    );
`else
    modport master (
        output start, abort, win_len, byte_valid, tx_byte, rx_byte,
        input  busy, done, err_bits, err_bytes, byte_cnt
    );

    modport slave (
        input  start, abort, win_len, byte_valid, tx_byte, rx_byte,
        output busy, done, err_bits, err_bytes, byte_cnt
    );
`endif

endinterface

// File: rtl/bit_err_popcnt.sv
// Combinational bit-error count between an expected and a received word,
// plus a flag marking the word as errored.
module bit_err_popcnt #(
    parameter int WIDTH = 8,
    parameter int PC_W  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] tx,
    input  logic [WIDTH-1:0] rx,
    output logic [PC_W-1:0]  pc,
    output logic             nz
);

    logic [WIDTH-1:0] diff;

    assign diff = tx ^ rx;
    assign nz   = |diff;

    // NOTE: pc gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
    end

endmodule

// File: rtl/ber_measure_ctrl.sv
// Sequences one bit-error-ratio window: compares tx/rx words through a two-stage
// pipe and reports saturating error counts. BER_ALARM_EN adds a threshold alarm.
module ber_measure_ctrl
    import ber_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    ber_measure_ctrl_if.slave bus
);

    localparam int PC_W = $clog2(WIDTH + 1);

    ber_state_e       state_q, state_d;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] byte_cnt_q;
    logic [WIN_W-1:0] err_bytes_q;
    logic [CNT_W-1:0] err_bits_q;
    logic [CNT_W-1:0] err_bits_d;
    logic [CNT_W:0]   bits_sum;
    logic [PC_W-1:0]  pc, pc_q;
    logic             nz, nz_q, pipe_vld_q;
    logic             start_ok, accept, last_word, stage2;

    bit_err_popcnt #(.WIDTH(WIDTH), .PC_W(PC_W)) u_popcnt (
        .tx (bus.tx_byte),
        .rx (bus.rx_byte),
        .pc (pc),
        .nz (nz)
    );

    assign start_ok  = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign accept    = (state_q == ST_MEASURE) && bus.byte_valid && !bus.abort;
    assign last_word = accept && ((byte_cnt_q + WIN_W'(1)) == win_len_q);
    assign stage2    = pipe_vld_q && ((state_q == ST_MEASURE) || (state_q == ST_FLUSH));

    // Widen by one bit so a carry out of the accumulator pins it at all-ones.
    always_comb begin
        bits_sum   = {1'b0, err_bits_q} + (CNT_W + 1)'(pc_q);
        err_bits_d = err_bits_q;
        if (stage2) begin
            err_bits_d = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (bus.win_len == '0) ? ST_DONE : ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (bus.abort)      state_d = ST_IDLE;
                else if (last_word) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = bus.abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_len_q   <= '0;
            byte_cnt_q  <= '0;
            err_bits_q  <= '0;
            err_bytes_q <= '0;
            pc_q        <= '0;
            nz_q        <= 1'b0;
            pipe_vld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                win_len_q   <= bus.win_len;
                byte_cnt_q  <= '0;
                err_bits_q  <= '0;
                err_bytes_q <= '0;
                pc_q        <= '0;
                nz_q        <= 1'b0;
                pipe_vld_q  <= 1'b0;
            end else begin
                pipe_vld_q <= accept;
                if (accept) begin
                    pc_q       <= pc;
                    nz_q       <= nz;
                    byte_cnt_q <= byte_cnt_q + WIN_W'(1);
                end
                err_bits_q <= err_bits_d;
                if (stage2) begin
                    err_bytes_q <= err_bytes_q + WIN_W'(nz_q);
                end
            end
        end
    end

    assign bus.busy      = (state_q == ST_MEASURE) || (state_q == ST_FLUSH);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err_bits  = err_bits_q;
    assign bus.err_bytes = err_bytes_q;
    assign bus.byte_cnt  = byte_cnt_q;

`ifdef BER_ALARM_EN
    logic [CNT_W-1:0] thresh_q;
    logic             alarm_q;

    // Compare against the next count so the alarm is already up when done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            alarm_q  <= 1'b0;
        end else if (start_ok) begin
            thresh_q <= bus.err_thresh;
            alarm_q  <= 1'b0;
        end else if (err_bits_d > thresh_q) begin
            alarm_q  <= 1'b1;
        end
    end

    assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_ber_measure_ctrl.sv
// Scoreboard bench for ber_measure_ctrl: randomized windows against an arithmetic
// reference model; a narrow accumulator makes saturation reachable.
module tb_ber_measure_ctrl;
    import ber_pkg::*;

    localparam int WIDTH = 8;
    localparam int WIN_W = 32;
    localparam int CNT_W = 8;
    localparam longint SAT_MAX = (64'd1 << CNT_W) - 1;

    typedef struct {
        longint      bits;
        longint      bytes;
        longint      cnt;
        int unsigned at;
        bit          alarm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    bit          prev_done = 1'b0;
    logic [WIDTH-1:0] dir_tx[$];
    logic [WIDTH-1:0] dir_rx[$];

    ber_measure_ctrl_if #(.WIDTH(WIDTH), .WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

    ber_measure_ctrl #(.WIDTH(WIDTH), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected window result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_pulse_width", prev_done, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.at);
                check("err_bits", bus.err_bits, mon_e.bits);
                check("err_bytes", bus.err_bytes, mon_e.bytes);
                check("byte_cnt", bus.byte_cnt, mon_e.cnt);
                check("busy_at_done", bus.busy, 0);
`ifdef BER_ALARM_EN
                check("alarm_at_done", bus.alarm, mon_e.alarm);
`endif
            end
        end
        prev_done = rst ? 1'b0 : bus.done;
    end

    task automatic wait_drained(input string name);
        for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done expected done within 12 cycles", name);
            sb.delete();
        end
    endtask

    task automatic start_win(input int unsigned len, input longint thresh);
        exp_t e;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_len = len;
`ifdef BER_ALARM_EN
        bus.err_thresh = thresh[CNT_W-1:0];
`endif
        if (len == 0) begin
            e = '{bits: 0, bytes: 0, cnt: 0, at: cyc + 1, alarm: 1'b0};
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.win_len = $urandom;
    endtask

    // Drives one window; words come from dir_tx/dir_rx when loaded, else random.
    task automatic run_window(input int unsigned len, input int gap_max, input longint thresh,
                              input bit all_err, input bit poke_start);
        longint      bits = 0;
        longint      bytes = 0;
        int unsigned last = 0;
        logic [WIDTH-1:0] tx, rx;
        exp_t e;
        start_win(len, thresh);
        check("busy_in_measure", bus.busy, 1);
        for (int i = 0; i < int'(len); i++) begin
            for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
                bus.byte_valid = 1'b0;
                bus.tx_byte    = $urandom;
                bus.rx_byte    = $urandom;
                @(negedge clk);
            end
            if (dir_tx.size() != 0) begin
                tx = dir_tx.pop_front();
                rx = dir_rx.pop_front();
            end else begin
                tx = $urandom;
                if (all_err)                  rx = ~tx;
                else if ($urandom_range(1, 0)) rx = tx;
                else                          rx = tx ^ WIDTH'($urandom);
            end
            bus.byte_valid = 1'b1;
            bus.tx_byte    = tx;
            bus.rx_byte    = rx;
            bits  += $countones(tx ^ rx);
            bytes += (tx != rx) ? 1 : 0;
            last   = cyc;
            if (poke_start && i == int'(len / 2)) begin
                bus.start   = 1'b1;
                bus.win_len = 3;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        e.bits  = (bits > SAT_MAX) ? SAT_MAX : bits;
        e.bytes = bytes;
        e.cnt   = len;
        e.at    = last + 2;
        e.alarm = (e.bits > thresh);
        sb.push_back(e);
        // Words offered after the window closes must be ignored.
        bus.byte_valid = 1'b1;
        bus.tx_byte    = 8'h00;
        bus.rx_byte    = 8'hFF;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        wait_drained("window_done_timeout");
    endtask

    initial begin
        longint      bits;
        longint      bytes;
        logic [WIDTH-1:0] tx, rx;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.win_len = '0;
        bus.byte_valid = 1'b0;
        bus.tx_byte = '0;
        bus.rx_byte = '0;
`ifdef BER_ALARM_EN
        bus.err_thresh = '0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err_bits", bus.err_bits, 0);
        check("reset_err_bytes", bus.err_bytes, 0);
        check("reset_byte_cnt", bus.byte_cnt, 0);
        rst = 1'b0;

        // Directed window: four consecutive words, 14 bit errors over 3 bytes.
        dir_tx = '{8'd8, 8'd100, 8'd250, 8'd0};
        dir_rx = '{8'd7, 8'd120, 8'd250, 8'd251};
        run_window(4, 0, 100, 1'b0, 1'b0);

        // Error-free window with gaps between valid words.
        for (int i = 0; i < 3; i++) begin
            tx = $urandom;
            dir_tx.push_back(tx);
            dir_rx.push_back(tx);
        end
        run_window(3, 3, 100, 1'b0, 1'b0);

        // Zero-length window: done one cycle after start, busy never asserted.
        start_win(0, 0);
        check("zero_win_busy", bus.busy, 0);
        wait_drained("zero_win_timeout");

        // Abort after five words: counts held, no done.
        start_win(10, 100);
        bits = 0;
        bytes = 0;
        for (int i = 0; i < 5; i++) begin
            tx = $urandom;
            rx = tx ^ WIDTH'($urandom);
            bus.byte_valid = 1'b1;
            bus.tx_byte = tx;
            bus.rx_byte = rx;
            bits  += $countones(tx ^ rx);
            bytes += (tx != rx) ? 1 : 0;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_byte_cnt", bus.byte_cnt, 5);
        check("abort_err_bits", bus.err_bits, (bits > SAT_MAX) ? SAT_MAX : bits);
        check("abort_err_bytes", bus.err_bytes, bytes);

        // start together with abort in IDLE is refused; counts stay held.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.win_len = 6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("start_abort_byte_cnt", bus.byte_cnt, 5);

        // Saturation: 40 fully errored words exceed the 8-bit accumulator.
        run_window(40, 0, 50, 1'b1, 1'b0);

        // Reset mid-window returns everything to the reset state.
        start_win(8, 100);
        for (int i = 0; i < 3; i++) begin
            bus.byte_valid = 1'b1;
            bus.tx_byte = 8'h0F;
            bus.rx_byte = 8'hF0;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_err_bits", bus.err_bits, 0);
        check("midrst_err_bytes", bus.err_bytes, 0);
        check("midrst_byte_cnt", bus.byte_cnt, 0);
        rst = 1'b0;

`ifdef BER_ALARM_EN
        dir_tx = '{8'd0};
        dir_rx = '{8'd255};
        run_window(1, 0, 5, 1'b0, 1'b0);
        check("alarm_held", bus.alarm, 1);
        start_win(2, 200);
        check("alarm_cleared_by_start", bus.alarm, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
`endif

        // Randomized windows, some with a stray start pulse mid-window.
        for (int w = 0; w < 30; w++) begin
            run_window($urandom_range(20, 1), $urandom_range(3, 0),
                       $urandom_range(60, 0), 1'b0, (w % 3) == 0);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
